flash_cmd_sequencer: RTL and testbench
======================================

// Module: flash_cmd_sequencer
// PURPOSE
//  Sequences JEDEC word-mode command cycles (program, sector erase, chip erase, read) on the SD loader
//  flash bus. Used while the board is in MCU mode, in place of bit-banged nFLASH_WE/nFLASH_OE strobes.
//  Accepts one request at a time and drives FLASH_ADDR/FLASH_DOUT/nFLASH_WE/nFLASH_OE with fixed timing.
//  Waits on nFLASH_BUSY with a timeout, then returns one response per request.
// PARAMETERS
//  SETUP_CYC    2       cycles addr/data stable before nFLASH_WE or nFLASH_OE falls (>=1)
//  WE_CYC       3       cycles nFLASH_WE held low per bus write (>=1)
//  RD_CYC       4       cycles nFLASH_OE held low before FLASH_DIN is sampled (>=1)
//  BUSY_DLY     4       cycles ignored after the last command write, before nFLASH_BUSY is checked (covers tBUSY)
//  TIMEOUT_CYC  2**24   max cycles in BUSY_DLY+BUSY_WAIT before error; counter is 25 bits wide
// PORTS
//  CLK_MCU      in   1   single clock, all logic on posedge
//  RESET        in   1   synchronous, active-high reset
//  REQ_VALID    in   1   request strobe
//  REQ_READY    out  1   high only in IDLE; request accepted on REQ_VALID&REQ_READY
//  REQ_CMD      in   2   0=read 1=program word 2=sector erase 3=chip erase
//  REQ_ADDR     in   18  word address [18:1]; for sector erase, any address in the sector
//  REQ_DATA     in   16  program data (ignored for other commands)
//  RSP_VALID    out  1   one-cycle pulse when a request completes
//  RSP_DATA     out  16  read data (valid with RSP_VALID, cmd 0); holds last value otherwise
//  RSP_ERR      out  1   with RSP_VALID: 1 = busy timeout
//  FLASH_ADDR   out  18  flash word address
//  FLASH_DOUT   out  16  flash write data
//  FLASH_DRIVE  out  1   1 = FLASH_DOUT is to be driven onto the data bus
//  FLASH_DIN    in   16  flash read data
//  nFLASH_WE    out  1   flash write enable, active low, registered
//  nFLASH_OE    out  1   flash output enable, active low, registered
//  nFLASH_BUSY  in   1   flash RY/BY#, asynchronous; 2-FF synchronised inside
//  SEQ_BUSY     out  1   ~REQ_READY
// BEHAVIOUR
//  - Reset values: REQ_READY=1, RSP_VALID=0, RSP_ERR=0, RSP_DATA=0, FLASH_ADDR=0, FLASH_DOUT=0,
//    FLASH_DRIVE=0, nFLASH_WE=1, nFLASH_OE=1, state=IDLE. RESET mid-op aborts with no response.
//    nFLASH_WE/nFLASH_OE are high the cycle after RESET is sampled.
//  - Request latch: on acceptance, cmd/addr/data are latched. Inputs are don't-care until the next IDLE.
//  - States: IDLE, W_SETUP, W_LOW, W_HOLD, BUSY_DLY, BUSY_WAIT, R_SETUP, R_LOW, DONE.
//  - Write step k (addr,data):
//    W_SETUP: SETUP_CYC cycles, FLASH_DRIVE=1, nWE=1.
//    W_LOW: WE_CYC cycles, nWE=0.
//    W_HOLD: 1 cycle, nWE=1, addr/data unchanged.
//    Total SETUP_CYC+WE_CYC+1 cycles per step. After W_HOLD, go to the next step's W_SETUP, or to BUSY_DLY after the last step.
//  - Step tables (word addr, data), unlock addresses with upper bits 0:
//    program: (555,AA) (2AA,55) (555,A0) (A,D)
//    sector erase: (555,AA) (2AA,55) (555,80) (555,AA) (2AA,55) (A,30)
//    chip erase: same first 5 steps as sector erase, then (555,10)
//  - BUSY_DLY: BUSY_DLY cycles, FLASH_DRIVE=0. BUSY_WAIT: exit when synced nFLASH_BUSY=1.
//    Busy already high at entry to BUSY_WAIT exits next cycle.
//  - Timeout counter clears on entry to BUSY_DLY and increments each cycle in BUSY_DLY/BUSY_WAIT.
//    At TIMEOUT_CYC, go to DONE with RSP_ERR=1. Ready and timeout in the same cycle: ready wins (ERR=0).
//  - Read: R_SETUP SETUP_CYC cycles (nOE=1, FLASH_DRIVE=0), then R_LOW RD_CYC cycles with nOE=0.
//    FLASH_DIN is captured into RSP_DATA on the last R_LOW cycle. nOE returns high on entry to DONE.
//  - DONE: 1 cycle, RSP_VALID=1, then IDLE. REQ_READY rises the cycle after RSP_VALID.
//    Earliest back-to-back acceptance is that cycle.
//  - nFLASH_WE and nFLASH_OE are never low in the same cycle. FLASH_DRIVE=0 whenever nOE=0.
// TESTING
//  - Program A=0x12345 D=0xBEEF, busy model low 10 cycles -> 4 WE pulses at 555/AA, 2AA/55, 555/A0, 12345/BEEF.
//    Each pulse is WE_CYC wide. Then RSP_VALID with ERR=0; latency counted and checked.
//  - Read A=0x00100, model returns 0x5A5A -> nOE low exactly RD_CYC cycles, no WE pulse, RSP_DATA=0x5A5A.
//  - Sector erase A=0x20000 -> 6 steps, last is 20000/30. Chip erase -> last step 555/10.
//  - nFLASH_BUSY stuck low, TIMEOUT_CYC=64 -> RSP_VALID with ERR=1, 64 cycles after BUSY_DLY entry.
//    REQ_READY high the next cycle.
//  - RESET asserted during W_LOW of step 2 -> nWE=1 next cycle, no RSP_VALID, REQ_READY=1.
//    A new program request then completes normally.
//  - REQ_VALID held high continuously, 3 requests -> each accepted only in IDLE, exactly 3 RSP_VALID pulses.

Source files
------------

// File: rtl/flash_cmd_sequencer.sv
// JEDEC word-mode command sequencer for the loader flash bus: one request at a time,
// fixed strobe timing, RY/BY# wait with timeout, one response per request.
module flash_cmd_sequencer #(
    parameter int SETUP_CYC   = 2,
    parameter int WE_CYC      = 3,
    parameter int RD_CYC      = 4,
    parameter int BUSY_DLY    = 4,
    parameter int TIMEOUT_CYC = 2**24
) (
    input  logic        CLK_MCU,
    input  logic        RESET,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [1:0]  REQ_CMD,
    input  logic [17:0] REQ_ADDR,
    input  logic [15:0] REQ_DATA,
    output logic        RSP_VALID,
    output logic [15:0] RSP_DATA,
    output logic        RSP_ERR,
    output logic [17:0] FLASH_ADDR,
    output logic [15:0] FLASH_DOUT,
    output logic        FLASH_DRIVE,
    input  logic [15:0] FLASH_DIN,
    output logic        nFLASH_WE,
    output logic        nFLASH_OE,
    input  logic        nFLASH_BUSY,
    output logic        SEQ_BUSY
);

    localparam int PH_MAX1 = (SETUP_CYC > WE_CYC) ? SETUP_CYC : WE_CYC;
    localparam int PH_MAX2 = (RD_CYC > BUSY_DLY) ? RD_CYC : BUSY_DLY;
    localparam int PH_MAX  = (PH_MAX1 > PH_MAX2) ? PH_MAX1 : PH_MAX2;
    localparam int PH_W    = $clog2(PH_MAX + 1);
    localparam logic [24:0] TO_LAST = 25'(TIMEOUT_CYC - 1);

    localparam logic [1:0] CMD_READ   = 2'd0;
    localparam logic [1:0] CMD_PROG   = 2'd1;
    localparam logic [1:0] CMD_SECTOR = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE, S_W_SETUP, S_W_LOW, S_W_HOLD, S_BUSY_DLY,
        S_BUSY_WAIT, S_R_SETUP, S_R_LOW, S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [1:0]      r_cmd;
    logic [17:0]     r_addr;
    logic [15:0]     r_data;
    logic [2:0]      r_step;
    logic [2:0]      w_step_next;
    logic [PH_W-1:0] r_ph;
    logic [PH_W-1:0] w_ph_next;
    logic [24:0]     r_to_cnt;
    logic            r_busy_meta;
    logic            r_busy_sync;
    logic            r_we_n;
    logic            r_oe_n;
    logic            r_drive;
    logic [17:0]     r_flash_addr;
    logic [15:0]     r_flash_dout;
    logic            r_rsp_valid;
    logic            r_rsp_err;
    logic [15:0]     r_rsp_data;

    logic            w_err_next;
    logic            w_to_hit;
    logic            w_last_step;
    logic [1:0]      w_cmd_eff;
    logic [17:0]     w_addr_eff;
    logic [15:0]     w_data_eff;
    logic [17:0]     w_tbl_addr;
    logic [15:0]     w_tbl_data;

    assign w_to_hit    = (r_to_cnt == TO_LAST);
    assign w_last_step = (r_cmd == CMD_PROG) ? (r_step == 3'd3) : (r_step == 3'd5);

    // In IDLE the table is looked up from the live request so the first step's
    // address/data are on the bus in the very first W_SETUP cycle.
    assign w_cmd_eff  = (r_state == S_IDLE) ? REQ_CMD  : r_cmd;
    assign w_addr_eff = (r_state == S_IDLE) ? REQ_ADDR : r_addr;
    assign w_data_eff = (r_state == S_IDLE) ? REQ_DATA : r_data;

    always_comb begin
        w_tbl_addr = 18'h00555;
        w_tbl_data = 16'h00AA;
        if (w_cmd_eff == CMD_PROG) begin
            case (w_step_next)
                3'd0:    begin w_tbl_addr = 18'h00555; w_tbl_data = 16'h00AA; end
                3'd1:    begin w_tbl_addr = 18'h002AA; w_tbl_data = 16'h0055; end
                3'd2:    begin w_tbl_addr = 18'h00555; w_tbl_data = 16'h00A0; end
                default: begin w_tbl_addr = w_addr_eff; w_tbl_data = w_data_eff; end
            endcase
        end else begin
            case (w_step_next)
                3'd0:    begin w_tbl_addr = 18'h00555; w_tbl_data = 16'h00AA; end
                3'd1:    begin w_tbl_addr = 18'h002AA; w_tbl_data = 16'h0055; end
                3'd2:    begin w_tbl_addr = 18'h00555; w_tbl_data = 16'h0080; end
                3'd3:    begin w_tbl_addr = 18'h00555; w_tbl_data = 16'h00AA; end
                3'd4:    begin w_tbl_addr = 18'h002AA; w_tbl_data = 16'h0055; end
                default: begin
                    if (w_cmd_eff == CMD_SECTOR) begin
                        w_tbl_addr = w_addr_eff;
                        w_tbl_data = 16'h0030;
                    end else begin
                        w_tbl_addr = 18'h00555;
                        w_tbl_data = 16'h0010;
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_step_next  = r_step;
        w_err_next   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (REQ_VALID) begin
                    w_step_next  = 3'd0;
                    w_state_next = (REQ_CMD == CMD_READ) ? S_R_SETUP : S_W_SETUP;
                end
            end
            S_W_SETUP: if (r_ph == PH_W'(SETUP_CYC - 1)) w_state_next = S_W_LOW;
            S_W_LOW:   if (r_ph == PH_W'(WE_CYC - 1))    w_state_next = S_W_HOLD;
            S_W_HOLD: begin
                if (w_last_step) begin
                    w_state_next = S_BUSY_DLY;
                end else begin
                    w_step_next  = r_step + 3'd1;
                    w_state_next = S_W_SETUP;
                end
            end
            S_BUSY_DLY: begin
                if (w_to_hit) begin
                    w_state_next = S_DONE;
                    w_err_next   = 1'b1;
                end else if (r_ph == PH_W'(BUSY_DLY - 1)) begin
                    w_state_next = S_BUSY_WAIT;
                end
            end
            S_BUSY_WAIT: begin
                // A ready flash takes priority over a timeout in the same cycle.
                if (r_busy_sync) begin
                    w_state_next = S_DONE;
                end else if (w_to_hit) begin
                    w_state_next = S_DONE;
                    w_err_next   = 1'b1;
                end
            end
            S_R_SETUP: if (r_ph == PH_W'(SETUP_CYC - 1)) w_state_next = S_R_LOW;
            S_R_LOW:   if (r_ph == PH_W'(RD_CYC - 1))    w_state_next = S_DONE;
            S_DONE:    w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    assign w_ph_next = (w_state_next != r_state) ? '0 : r_ph + PH_W'(1);

    always_ff @(posedge CLK_MCU) begin
        if (RESET) begin
            r_state      <= S_IDLE;
            r_cmd        <= 2'd0;
            r_addr       <= 18'd0;
            r_data       <= 16'd0;
            r_step       <= 3'd0;
            r_ph         <= '0;
            r_to_cnt     <= 25'd0;
            r_busy_meta  <= 1'b0;
            r_busy_sync  <= 1'b0;
            r_we_n       <= 1'b1;
            r_oe_n       <= 1'b1;
            r_drive      <= 1'b0;
            r_flash_addr <= 18'd0;
            r_flash_dout <= 16'd0;
            r_rsp_valid  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_data   <= 16'd0;
        end else begin
            r_state     <= w_state_next;
            r_step      <= w_step_next;
            r_ph        <= w_ph_next;
            r_busy_meta <= nFLASH_BUSY;
            r_busy_sync <= r_busy_meta;

            if (r_state == S_IDLE && REQ_VALID) begin
                r_cmd  <= REQ_CMD;
                r_addr <= REQ_ADDR;
                r_data <= REQ_DATA;
            end

            if (w_state_next == S_BUSY_DLY && r_state != S_BUSY_DLY) begin
                r_to_cnt <= 25'd0;
            end else if (r_state == S_BUSY_DLY || r_state == S_BUSY_WAIT) begin
                r_to_cnt <= r_to_cnt + 25'd1;
            end

            // Strobes and bus outputs follow the next state so they are registered.
            r_we_n  <= (w_state_next != S_W_LOW);
            r_oe_n  <= (w_state_next != S_R_LOW);
            r_drive <= (w_state_next == S_W_SETUP) || (w_state_next == S_W_LOW) ||
                       (w_state_next == S_W_HOLD);

            if (w_state_next == S_W_SETUP && r_state != S_W_SETUP) begin
                r_flash_addr <= w_tbl_addr;
                r_flash_dout <= w_tbl_data;
            end else if (w_state_next == S_R_SETUP && r_state == S_IDLE) begin
                r_flash_addr <= REQ_ADDR;
            end

            if (r_state == S_R_LOW && w_state_next == S_DONE) begin
                r_rsp_data <= FLASH_DIN;
            end

            r_rsp_valid <= (w_state_next == S_DONE);
            r_rsp_err   <= (w_state_next == S_DONE) && w_err_next;
        end
    end

    assign REQ_READY   = (r_state == S_IDLE);
    assign SEQ_BUSY    = ~REQ_READY;
    assign RSP_VALID   = r_rsp_valid;
    assign RSP_ERR     = r_rsp_err;
    assign RSP_DATA    = r_rsp_data;
    assign FLASH_ADDR  = r_flash_addr;
    assign FLASH_DOUT  = r_flash_dout;
    assign FLASH_DRIVE = r_drive;
    assign nFLASH_WE   = r_we_n;
    assign nFLASH_OE   = r_oe_n;

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// Directed bench for flash_cmd_sequencer: a flash bus model (busy, read data) plus
// a strobe monitor; each task drives one scenario and checks hand-computed values.
module tb_flash_cmd_sequencer;

    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic        REQ_VALID = 1'b0;
    logic        REQ_READY;
    logic [1:0]  REQ_CMD = 2'd0;
    logic [17:0] REQ_ADDR = 18'd0;
    logic [15:0] REQ_DATA = 16'd0;
    logic        RSP_VALID;
    logic [15:0] RSP_DATA;
    logic        RSP_ERR;
    logic [17:0] FLASH_ADDR;
    logic [15:0] FLASH_DOUT;
    logic        FLASH_DRIVE;
    logic [15:0] FLASH_DIN;
    logic        nFLASH_WE;
    logic        nFLASH_OE;
    logic        nFLASH_BUSY;
    logic        SEQ_BUSY;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    flash_cmd_sequencer #(.SETUP_CYC(2), .WE_CYC(3), .RD_CYC(4), .BUSY_DLY(4), .TIMEOUT_CYC(64)) dut (
        .CLK_MCU(clk), .RESET(RESET), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_CMD(REQ_CMD), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA), .RSP_VALID(RSP_VALID),
        .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR), .FLASH_ADDR(FLASH_ADDR), .FLASH_DOUT(FLASH_DOUT),
        .FLASH_DRIVE(FLASH_DRIVE), .FLASH_DIN(FLASH_DIN), .nFLASH_WE(nFLASH_WE),
        .nFLASH_OE(nFLASH_OE), .nFLASH_BUSY(nFLASH_BUSY), .SEQ_BUSY(SEQ_BUSY)
    );

    // Flash model: read data while OE is low; busy low for 10 cycles after the last WE sample.
    logic [15:0] rd_val = 16'h5A5A;
    logic        busy_stuck = 1'b0;
    logic        busy_q = 1'b1;
    int          busy_cnt = 0;
    assign FLASH_DIN   = nFLASH_OE ? 16'h0000 : rd_val;
    assign nFLASH_BUSY = busy_q;

    always @(posedge clk) begin
        if (busy_stuck) begin
            busy_q <= 1'b0;
        end else if (!nFLASH_WE) begin
            busy_cnt <= 10;
            busy_q   <= 1'b0;
        end else begin
            busy_cnt <= (busy_cnt > 0) ? busy_cnt - 1 : 0;
            busy_q   <= (busy_cnt <= 1);
        end
    end

    // Strobe monitor (collects only; tasks compare).
    logic [17:0] we_addr [64];
    logic [15:0] we_data [64];
    int          we_w [64];
    int          np = 0;
    int          cur_w = 0;
    logic        prev_we = 1'b1;
    int          oe_low = 0;
    logic [17:0] oe_addr = 18'd0;
    int          viol = 0;
    int          drv_bad = 0;
    int          rsp_cnt = 0;

    always @(negedge clk) begin
        if (!nFLASH_WE) begin
            if (prev_we) begin
                if (np < 64) begin
                    we_addr[np] = FLASH_ADDR;
                    we_data[np] = FLASH_DOUT;
                end
                cur_w = 1;
            end else begin
                cur_w++;
            end
            if (!FLASH_DRIVE) drv_bad++;
        end else if (!prev_we) begin
            if (np < 64) we_w[np] = cur_w;
            np++;
        end
        prev_we = nFLASH_WE;
        if (!nFLASH_OE) begin
            oe_low++;
            oe_addr = FLASH_ADDR;
            if (FLASH_DRIVE) viol++;
        end
        if (!nFLASH_WE && !nFLASH_OE) viol++;
        if (RSP_VALID) rsp_cnt++;
    end

    // Issue one request; lat = cycle index of RSP_VALID counted from the acceptance edge.
    task automatic do_req(input logic [1:0] cmd, input logic [17:0] addr, input logic [15:0] data,
                          output int lat, output logic err, output logic [15:0] d, output logic to);
        @(negedge clk);
        REQ_VALID = 1'b1;
        REQ_CMD   = cmd;
        REQ_ADDR  = addr;
        REQ_DATA  = data;
        @(posedge clk);
        @(negedge clk);
        REQ_VALID = 1'b0;
        REQ_CMD   = 2'd3;
        REQ_ADDR  = 18'h3FFFF;
        REQ_DATA  = 16'hFFFF;
        lat = 0;
        to  = 1'b0;
        while (!RSP_VALID) begin
            if (lat >= 1000) begin
                to = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        err = RSP_ERR;
        d   = RSP_DATA;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({REQ_READY, SEQ_BUSY, RSP_VALID, RSP_ERR} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy/busy/vld/err=%b, want 1000", {REQ_READY, SEQ_BUSY, RSP_VALID, RSP_ERR});
        end
        checks++;
        if ({nFLASH_WE, nFLASH_OE, FLASH_DRIVE} !== 3'b110) begin
            errors++;
            $display("FAIL reset_strobes: got we/oe/drive=%b, want 110", {nFLASH_WE, nFLASH_OE, FLASH_DRIVE});
        end
        checks++;
        if ({FLASH_ADDR, FLASH_DOUT, RSP_DATA} !== 50'd0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h dout=%h rsp=%h, want 0", FLASH_ADDR, FLASH_DOUT, RSP_DATA);
        end
        RESET = 1'b0;
        repeat (3) @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_program();
        int lat; logic err; logic [15:0] d; logic to;
        int np0; int oe0;
        logic [17:0] ea [4];
        logic [15:0] ed [4];
        ea[0] = 18'h00555; ed[0] = 16'h00AA;
        ea[1] = 18'h002AA; ed[1] = 16'h0055;
        ea[2] = 18'h00555; ed[2] = 16'h00A0;
        ea[3] = 18'h12345; ed[3] = 16'hBEEF;
        np0 = np; oe0 = oe_low;
        do_req(2'd1, 18'h12345, 16'hBEEF, lat, err, d, to);
        checks++;
        if (to || lat != 36 || err !== 1'b0) begin
            errors++;
            $display("FAIL prog_rsp: got lat=%0d err=%b timeout=%b, want lat=36 err=0", lat, err, to);
        end
        @(negedge clk);
        checks++;
        if (REQ_READY !== 1'b1) begin
            errors++;
            $display("FAIL prog_ready: got %b, want 1", REQ_READY);
        end
        checks++;
        if (np - np0 != 4 || oe_low != oe0) begin
            errors++;
            $display("FAIL prog_pulses: got we=%0d oe_cycles=%0d, want we=4 oe_cycles=0", np - np0, oe_low - oe0);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (we_addr[np0+k] !== ea[k] || we_data[np0+k] !== ed[k] || we_w[np0+k] != 3) begin
                errors++;
                $display("FAIL prog_step%0d: got %h/%h w=%0d, want %h/%h w=3", k,
                         we_addr[np0+k], we_data[np0+k], we_w[np0+k], ea[k], ed[k]);
            end
        end
        $display("test_program lat=%0d err=%b pulses=%0d", lat, err, np - np0);
    endtask

    task automatic test_read();
        int lat; logic err; logic [15:0] d; logic to;
        int np0; int oe0;
        np0 = np; oe0 = oe_low; rd_val = 16'h5A5A;
        do_req(2'd0, 18'h00100, 16'h0000, lat, err, d, to);
        checks++;
        if (to || lat != 6 || err !== 1'b0 || d !== 16'h5A5A) begin
            errors++;
            $display("FAIL read_rsp: got lat=%0d err=%b data=%h, want lat=6 err=0 data=5a5a", lat, err, d);
        end
        @(negedge clk);
        checks++;
        if (oe_low - oe0 != 4 || np != np0 || oe_addr !== 18'h00100) begin
            errors++;
            $display("FAIL read_bus: got oe_cycles=%0d we=%0d addr=%h, want 4 0 00100", oe_low - oe0, np - np0, oe_addr);
        end
        checks++;
        if (RSP_DATA !== 16'h5A5A) begin
            errors++;
            $display("FAIL read_hold: got %h, want 5a5a", RSP_DATA);
        end
        $display("test_read lat=%0d data=%h", lat, d);
    endtask

    task automatic test_erase(input logic [1:0] cmd, input logic [17:0] addr);
        int lat; logic err; logic [15:0] d; logic to;
        int np0;
        logic [17:0] ea [6];
        logic [15:0] ed [6];
        ea[0] = 18'h00555; ed[0] = 16'h00AA;
        ea[1] = 18'h002AA; ed[1] = 16'h0055;
        ea[2] = 18'h00555; ed[2] = 16'h0080;
        ea[3] = 18'h00555; ed[3] = 16'h00AA;
        ea[4] = 18'h002AA; ed[4] = 16'h0055;
        ea[5] = (cmd == 2'd2) ? addr : 18'h00555;
        ed[5] = (cmd == 2'd2) ? 16'h0030 : 16'h0010;
        np0 = np;
        do_req(cmd, addr, 16'h1357, lat, err, d, to);
        checks++;
        if (to || lat != 48 || err !== 1'b0) begin
            errors++;
            $display("FAIL erase%0d_rsp: got lat=%0d err=%b, want lat=48 err=0", cmd, lat, err);
        end
        @(negedge clk);
        checks++;
        if (np - np0 != 6) begin
            errors++;
            $display("FAIL erase%0d_count: got %0d, want 6", cmd, np - np0);
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (we_addr[np0+k] !== ea[k] || we_data[np0+k] !== ed[k]) begin
                errors++;
                $display("FAIL erase%0d_step%0d: got %h/%h, want %h/%h", cmd, k,
                         we_addr[np0+k], we_data[np0+k], ea[k], ed[k]);
            end
        end
        $display("test_erase cmd=%0d lat=%0d last=%h/%h", cmd, lat, we_addr[np0+5], we_data[np0+5]);
    endtask

    task automatic test_sector_erase();
        test_erase(2'd2, 18'h20000);
    endtask

    task automatic test_chip_erase();
        test_erase(2'd3, 18'h3FFFF);
    endtask

    task automatic test_timeout();
        int lat; logic err; logic [15:0] d; logic to;
        busy_stuck = 1'b1;
        do_req(2'd1, 18'h00001, 16'h1111, lat, err, d, to);
        checks++;
        if (to || lat != 88 || err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_rsp: got lat=%0d err=%b, want lat=88 err=1", lat, err);
        end
        checks++;
        if (REQ_READY !== 1'b0) begin
            errors++;
            $display("FAIL timeout_ready_done: got %b, want 0", REQ_READY);
        end
        @(negedge clk);
        checks++;
        if (REQ_READY !== 1'b1 || RSP_VALID !== 1'b0 || RSP_ERR !== 1'b0) begin
            errors++;
            $display("FAIL timeout_after: got rdy=%b vld=%b err=%b, want 1 0 0", REQ_READY, RSP_VALID, RSP_ERR);
        end
        busy_stuck = 1'b0;
        repeat (3) @(negedge clk);
        $display("test_timeout lat=%0d err=%b", lat, err);
    endtask

    task automatic test_reset_midop();
        int lat; logic err; logic [15:0] d; logic to;
        int rsp0; int np0;
        @(negedge clk);
        REQ_VALID = 1'b1; REQ_CMD = 2'd1; REQ_ADDR = 18'h00777; REQ_DATA = 16'h4242;
        @(posedge clk);
        @(negedge clk);
        REQ_VALID = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (nFLASH_WE !== 1'b0 || FLASH_ADDR !== 18'h002AA) begin
            errors++;
            $display("FAIL midop_wlow: got we=%b addr=%h, want 0 002aa", nFLASH_WE, FLASH_ADDR);
        end
        rsp0 = rsp_cnt;
        RESET = 1'b1;
        @(negedge clk);
        checks++;
        if (nFLASH_WE !== 1'b1 || REQ_READY !== 1'b1 || SEQ_BUSY !== 1'b0 || FLASH_DRIVE !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset: got we=%b rdy=%b busy=%b drv=%b, want 1 1 0 0",
                     nFLASH_WE, REQ_READY, SEQ_BUSY, FLASH_DRIVE);
        end
        RESET = 1'b0;
        repeat (40) @(negedge clk);
        checks++;
        if (rsp_cnt != rsp0) begin
            errors++;
            $display("FAIL midop_norsp: got %0d responses, want 0", rsp_cnt - rsp0);
        end
        np0 = np;
        do_req(2'd1, 18'h0ABCD, 16'hCAFE, lat, err, d, to);
        checks++;
        if (to || lat != 36 || err !== 1'b0) begin
            errors++;
            $display("FAIL midop_again: got lat=%0d err=%b, want lat=36 err=0", lat, err);
        end
        @(negedge clk);
        checks++;
        if (np - np0 != 4 || we_addr[np0+3] !== 18'h0ABCD || we_data[np0+3] !== 16'hCAFE) begin
            errors++;
            $display("FAIL midop_last: got n=%0d %h/%h, want 4 0abcd/cafe", np - np0, we_addr[np0+3], we_data[np0+3]);
        end
        $display("test_reset_midop relat=%0d", lat);
    endtask

    task automatic test_back_to_back();
        int acc; int nrsp; int acc_cyc [3]; logic dropped; int rsp0;
        acc = 0; nrsp = 0; dropped = 1'b0; rsp0 = rsp_cnt;
        rd_val = 16'h1234;
        @(negedge clk);
        REQ_VALID = 1'b1; REQ_CMD = 2'd0; REQ_ADDR = 18'h00200;
        for (int c = 0; c < 60; c++) begin
            if (c > 0) @(negedge clk);
            if (REQ_READY && REQ_VALID) begin
                if (acc < 3) acc_cyc[acc] = c;
                acc++;
            end
            if (RSP_VALID) begin
                nrsp++;
                checks++;
                if (RSP_DATA !== 16'h1234) begin
                    errors++;
                    $display("FAIL b2b_data%0d: got %h, want 1234", nrsp, RSP_DATA);
                end
            end
            if (acc == 3 && !dropped && c == acc_cyc[2] + 1) begin
                REQ_VALID = 1'b0;
                dropped = 1'b1;
            end
        end
        checks++;
        if (acc != 3 || nrsp != 3 || rsp_cnt - rsp0 != 3) begin
            errors++;
            $display("FAIL b2b_count: got acc=%0d rsp=%0d, want 3 3", acc, nrsp);
        end
        checks++;
        if (acc_cyc[0] != 0 || acc_cyc[1] != 8 || acc_cyc[2] != 16) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d %0d %0d, want 0 8 16", acc_cyc[0], acc_cyc[1], acc_cyc[2]);
        end
        $display("test_back_to_back acc=%0d rsp=%0d", acc, nrsp);
    endtask

    initial begin
        test_reset();
        test_program();
        test_read();
        test_sector_erase();
        test_chip_erase();
        test_timeout();
        test_reset_midop();
        test_back_to_back();
        checks++;
        if (viol != 0 || drv_bad != 0) begin
            errors++;
            $display("FAIL strobe_rules: got overlap/drive violations=%0d we_undriven=%0d, want 0 0", viol, drv_bad);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
